// File: rtl/siren_controller_if.sv
// Signal bundle between the alarm FSM/timer side and the siren sequencer.
// master drives the request/tick/disarm inputs; slave is the sequencer itself.
interface siren_controller_if;
  logic       one_hz_tick;
  logic       alarm_request;
  logic       disarm;
  logic       enable_siren;
  logic       half_hz_enable;
  logic [1:0] siren_state;
  logic       timeout_done;

  modport master (
    output one_hz_tick, alarm_request, disarm,
    input  enable_siren, half_hz_enable, siren_state, timeout_done
  );

  modport slave (
    input  one_hz_tick, alarm_request, disarm,
    output enable_siren, half_hz_enable, siren_state, timeout_done
  );
endinterface

// File: rtl/siren_controller.sv
// Siren sequencer: request edge -> timed SOUNDING interval -> HOLDOFF -> IDLE, disarm wins.
// Optional SIREN_RETRIGGER_EN: a request edge while sounding restarts the interval.
module siren_controller #(
  parameter int unsigned ALARM_ON_TICKS = 10,
  parameter int unsigned HOLDOFF_TICKS  = 3,
  parameter int unsigned CNT_W          = 8
) (
  input logic               clk,
  input logic               rst_n,
  siren_controller_if.slave sif
);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StSounding = 2'b01,
    StHoldoff  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] OnLast   = CNT_W'(ALARM_ON_TICKS - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLDOFF_TICKS - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_en, w_en_nxt;
  logic             r_half, w_half_nxt;
  logic             r_done, w_done_nxt;
  logic             r_req_q;
  logic             w_req_rise;

  assign w_req_rise = sif.alarm_request & ~r_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_half  <= 1'b0;
      r_done  <= 1'b0;
      r_req_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_half  <= w_half_nxt;
      r_done  <= w_done_nxt;
      r_req_q <= sif.alarm_request;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_half_nxt  = r_half;
    w_done_nxt  = 1'b0;

    if (sif.disarm) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_en_nxt    = 1'b0;
      w_half_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // A tick coinciding with the request edge is deliberately not counted.
          if (w_req_rise) begin
            w_state_nxt = StSounding;
            w_cnt_nxt   = '0;
            w_en_nxt    = 1'b1;
            w_half_nxt  = 1'b1;
          end
        end
        StSounding: begin
`ifdef SIREN_RETRIGGER_EN
          if (w_req_rise) begin
            // Retrigger beats expiry; colour phase keeps running.
            w_cnt_nxt = '0;
            if (sif.one_hz_tick) begin
              w_half_nxt = ~r_half;
            end
          end else
`endif
          if (sif.one_hz_tick) begin
            if (r_cnt == OnLast) begin
              w_state_nxt = StHoldoff;
              w_cnt_nxt   = '0;
              w_en_nxt    = 1'b0;
              w_half_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_cnt_nxt  = r_cnt + 1'b1;
              w_half_nxt = ~r_half;
            end
          end
        end
        StHoldoff: begin
          if (sif.one_hz_tick) begin
            if (r_cnt == HoldLast) begin
              w_state_nxt = StIdle;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b0;
          w_half_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign sif.enable_siren   = r_en;
  assign sif.half_hz_enable = r_half;
  assign sif.siren_state    = r_state;
  assign sif.timeout_done   = r_done;

endmodule

// File: tb/tb_siren_controller.sv
// Scoreboard bench for siren_controller (ALARM_ON_TICKS=4, HOLDOFF_TICKS=2, tick every 10 clk).
// Stimulus pushes each expected output change; a negedge monitor pops on every observed change.
module tb_siren_controller;
  logic clk;
  logic rst_n;
  siren_controller_if sif ();

  siren_controller #(
    .ALARM_ON_TICKS(4),
    .HOLDOFF_TICKS (2),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output tuple: {state[1:0], enable_siren, half_hz_enable, timeout_done}
  logic [4:0] exp_q[$];
  logic [4:0] prev_out;
  logic       mon_on;
  int         tests;
  int         fails;

  function automatic logic [4:0] tup(input logic [1:0] s, input logic e, input logic h,
                                     input logic d);
    return {s, e, h, d};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got state=%b en=%b half=%b done=%b, want state=%b en=%b half=%b done=%b",
               name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [4:0] cur_out();
    return {sif.siren_state, sif.enable_siren, sif.half_hz_enable, sif.timeout_done};
  endfunction

  always @(negedge clk) begin
    if (mon_on && cur_out() !== prev_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_change: got %b, want no change from %b", cur_out(), prev_out);
      end else begin
        check("output_change", cur_out(), exp_q.pop_front());
      end
      prev_out = cur_out();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    repeat (9) step();
    sif.one_hz_tick = 1'b1;
    step();
    sif.one_hz_tick = 1'b0;
  endtask

  task automatic req_pulse();
    sif.alarm_request = 1'b1;
    step();
    sif.alarm_request = 1'b0;
  endtask

  task automatic push(input logic [1:0] s, input logic e, input logic h, input logic d);
    exp_q.push_back(tup(s, e, h, d));
  endtask

  // Expiry tick plus the following cycle where timeout_done drops again.
  task automatic push_expiry();
    push(2'b10, 1'b0, 1'b0, 1'b1);
    push(2'b10, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    mon_on            = 1'b0;
    prev_out          = '0;
    rst_n             = 1'b0;
    sif.one_hz_tick   = 1'b0;
    sif.alarm_request = 1'b1;
    sif.disarm        = 1'b0;

    // Reset held with request high: everything idle.
    repeat (3) step();
    check("reset_state", cur_out(), tup(2'b00, 1'b0, 1'b0, 1'b0));
    mon_on = 1'b1;

    // Level high through reset release counts as an edge; 1 clk latency.
    push(2'b01, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    check("reset_release_latency", cur_out(), tup(2'b01, 1'b1, 1'b1, 1'b0));
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push_expiry();                 tick();
    tick();
    push(2'b00, 1'b0, 1'b0, 1'b0); tick();
    repeat (5) step();
    sif.alarm_request = 1'b0;
    repeat (5) step();

    // Plain request pulse, then an ignored edge in HOLDOFF held high past its exit.
    push(2'b01, 1'b1, 1'b1, 1'b0); req_pulse();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push_expiry();                 tick();
    repeat (3) step();
    sif.alarm_request = 1'b1;
    step();
    check("holdoff_ignores_req", cur_out(), tup(2'b10, 1'b0, 1'b0, 1'b0));
    tick();
    push(2'b00, 1'b0, 1'b0, 1'b0); tick();
    repeat (15) step();
    check("no_retrigger_on_level", cur_out(), tup(2'b00, 1'b0, 1'b0, 1'b0));
    sif.alarm_request = 1'b0;
    repeat (3) step();

    // Disarm mid-interval; request edge and ticks while disarmed are ignored.
    push(2'b01, 1'b1, 1'b1, 1'b0); req_pulse();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    repeat (3) step();
    push(2'b00, 1'b0, 1'b0, 1'b0);
    sif.disarm = 1'b1;
    step();
    check("disarm_latency", cur_out(), tup(2'b00, 1'b0, 1'b0, 1'b0));
    repeat (2) step();
    req_pulse();
    tick();
    tick();
    check("disarm_blocks_req", cur_out(), tup(2'b00, 1'b0, 1'b0, 1'b0));
    sif.disarm = 1'b0;
    repeat (5) step();

    // Second request edge after the 3rd tick.
    push(2'b01, 1'b1, 1'b1, 1'b0); req_pulse();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    repeat (3) step();
    req_pulse();
`ifdef SIREN_RETRIGGER_EN
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    push_expiry();                 tick();
`else
    push_expiry();                 tick();
`endif
    tick();
    push(2'b00, 1'b0, 1'b0, 1'b0); tick();
    repeat (5) step();

    // Tick and request edge in the same cycle: that tick is not counted.
    repeat (9) step();
    push(2'b01, 1'b1, 1'b1, 1'b0);
    sif.one_hz_tick   = 1'b1;
    sif.alarm_request = 1'b1;
    step();
    sif.one_hz_tick   = 1'b0;
    sif.alarm_request = 1'b0;
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push(2'b01, 1'b1, 1'b1, 1'b0); tick();
    push(2'b01, 1'b1, 1'b0, 1'b0); tick();
    push_expiry();                 tick();
    tick();
    push(2'b00, 1'b0, 1'b0, 1'b0); tick();
    repeat (10) step();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expected: %0d changes never seen, want 0", exp_q.size());
    end
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
